seq_detector_param: RTL and testbench

Parametrised serial bit-pattern detector. It is the successor to the fixed 6-bit hard-coded Mealy detector. Pattern, length, overlap mode and Mealy/Moore output timing are run-time configurable. It adds input qualification (x_valid) and a saturating match counter. It sits on serial data paths, such as frame-sync and preamble search, between a deserialiser bit stream and control logic.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/sat_counter.sv | 27 ++
 rtl/seq_detector_param.sv | 108 ++++++++++
 tb/tb_seq_detector_param.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants for the parametrised sequence detector
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_CNT_W   = 8;

    localparam logic MODE_MEALY = 1'b0;
    localparam logic MODE_MOORE = 1'b1;

    localparam logic OVL_OFF = 1'b0;
    localparam logic OVL_ON  = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with clear-then-count priority
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // clear restarts from zero but still counts a coincident event; never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= inc ? W'(1) : '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - run-time configurable serial bit-pattern detector
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x_valid,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cfg_moore,
    input  logic               cnt_clear,
    output logic               y,
    output logic [CNT_W-1:0]   match_count
);

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic               r_moore;
    logic               r_y;

    // candidate window is history plus the bit arriving this cycle
    logic [MAX_LEN:0]   w_cand;
    logic [MAX_LEN:0]   w_pat;
    logic [MAX_LEN:0]   w_mask;
    logic               w_len_ok;
    logic               w_fill_ok;
    logic               w_hit;

    assign w_cand = {r_hist, x};
    assign w_pat  = {1'b0, r_pattern};

    // compare mask keeps only the low r_len bits of the window
    always_comb begin
        w_mask = '0;
        for (int i = 0; i <= MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    assign w_len_ok  = (r_len != '0) && (r_len <= LEN_W'(MAX_LEN));
    assign w_fill_ok = ({1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, r_len};
    assign w_hit     = x_valid && !cfg_load && w_len_ok && w_fill_ok
                       && (((w_cand ^ w_pat) & w_mask) == '0);

    // configuration latch; a load also invalidates any partial history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= OVL_ON;
            r_moore   <= MODE_MEALY;
        end else if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_overlap <= cfg_overlap;
            r_moore   <= cfg_moore;
        end
    end

    // history shift and fill tracking; non-overlap mode restarts after a hit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (cfg_load) begin
            r_fill <= '0;
        end else if (x_valid) begin
            r_hist <= {r_hist[MAX_LEN-2:0], x};
            if (w_hit && (r_overlap == OVL_OFF)) begin
                r_fill <= '0;
            end else if (r_fill != LEN_W'(MAX_LEN)) begin
                r_fill <= r_fill + LEN_W'(1);
            end
        end
    end

    // registered pulse for Moore timing, lives exactly one cycle
    always_ff @(posedge clk) begin
        if (rst || cfg_load) begin
            r_y <= 1'b0;
        end else begin
            r_y <= w_hit;
        end
    end

    assign y = rst ? 1'b0 : ((r_moore == MODE_MOORE) ? r_y : w_hit);

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clear),
        .inc   (w_hit),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - randomized and directed checks against a bit-queue model
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic               clk;
    logic               rst;
    logic               x_valid;
    logic               x;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cfg_moore;
    logic               cnt_clear;
    logic               y;
    logic [CNT_W-1:0]   match_count;

    int n_vec;
    int n_err;

    seq_detector_param #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x_valid     (x_valid),
        .x           (x),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_moore   (cfg_moore),
        .cnt_clear   (cnt_clear),
        .y           (y),
        .match_count (match_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: list of qualified bits since the last restart
    bit   mq[$];
    logic [MAX_LEN-1:0] m_pat;
    int   m_len;
    bit   m_ov;
    bit   m_moore;
    bit   m_yreg;
    int   m_cnt;

    function automatic bit model_hit(bit xv, bit xb, bit ld);
        if (!xv || ld) return 1'b0;
        if (m_len < 1 || m_len > MAX_LEN) return 1'b0;
        if (mq.size() < m_len - 1) return 1'b0;
        if (m_pat[0] != xb) return 1'b0;
        for (int k = 1; k < m_len; k++) begin
            if (m_pat[k] != mq[mq.size() - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pat   = '0;
        m_len   = 0;
        m_ov    = 1'b1;
        m_moore = 1'b0;
        m_yreg  = 1'b0;
        m_cnt   = 0;
    endtask

    // drives one cycle from a negedge, returns expected and observed y
    task automatic apply(input bit xv, input bit xb, input bit ld, input bit clr,
                         output bit ey, output logic oy);
        bit h;
        x_valid   = xv;
        x         = xb;
        cfg_load  = ld;
        cnt_clear = clr;
        #1;
        h  = model_hit(xv, xb, ld);
        ey = m_moore ? m_yreg : h;
        oy = y;
        @(posedge clk);
        if (ld) begin
            m_pat   = cfg_pattern;
            m_len   = int'(cfg_len);
            m_ov    = cfg_overlap;
            m_moore = cfg_moore;
            mq.delete();
            m_yreg  = 1'b0;
        end else begin
            if (xv) begin
                mq.push_back(xb);
                if (mq.size() > 64) void'(mq.pop_front());
                if (h && !m_ov) mq.delete();
            end
            m_yreg = h;
        end
        if (clr) m_cnt = h ? 1 : 0;
        else if (h && m_cnt < CNT_MAX) m_cnt++;
        @(negedge clk);
        x_valid   = 1'b0;
        cfg_load  = 1'b0;
        cnt_clear = 1'b0;
    endtask

    task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input int len, input bit ov, input bit mo);
        bit   ey;
        logic oy;
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ov;
        cfg_moore   = mo;
        apply(1'b0, 1'b0, 1'b1, 1'b0, ey, oy);
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bit   ey;
        logic oy;
        rst = 1'b1;
        x_valid = 1'b1;
        x = 1'b1;
        #1;
        n_vec++;
        if (y !== 1'b0) begin n_err++; $display("FAIL reset_y: got %b want 0", y); end
        x_valid = 1'b0;
        reset_cycle();
        n_vec++;
        if (match_count !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", match_count); end
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, ey, oy);
            n_vec++;
            if (oy !== 1'b0) begin n_err++; $display("FAIL disabled_y: cycle %0d got %b want 0", i, oy); end
        end
    endtask

    task automatic run_stream(input string nm, input bit mo, input bit ov, input int nexp, input int p1, input int p2);
        bit   s[11] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0};
        bit   ey;
        logic oy;
        int   ncyc;
        bit   want;
        load_cfg(8'b0011_1011, 6, ov, mo);
        apply(1'b0, 1'b0, 1'b0, 1'b1, ey, oy);
        ncyc = mo ? 11 : 10;
        for (int i = 0; i < ncyc; i++) begin
            apply(i < 10, s[i], 1'b0, 1'b0, ey, oy);
            want = (i == p1) || (i == p2);
            n_vec++;
            if (oy !== want) begin n_err++; $display("FAIL %s_y: cycle %0d got %b want %b", nm, i, oy, want); end
        end
        n_vec++;
        if (match_count !== CNT_W'(nexp)) begin
            n_err++; $display("FAIL %s_cnt: got %0d want %0d", nm, match_count, nexp);
        end
    endtask

    task automatic test_overlap_mealy();
        run_stream("ovl_mealy", 1'b0, 1'b1, 2, 5, 9);
    endtask

    task automatic test_no_overlap();
        run_stream("noovl", 1'b0, 1'b0, 1, 5, -1);
    endtask

    task automatic test_moore();
        run_stream("moore", 1'b1, 1'b1, 2, 6, 10);
    endtask

    task automatic test_gaps();
        bit   s[6] = '{1, 1, 1, 0, 1, 1};
        bit   ey;
        logic oy;
        bit   want;
        load_cfg(8'b0011_1011, 6, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, ey, oy);
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, s[i], 1'b0, 1'b0, ey, oy);
            want = (i == 5);
            n_vec++;
            if (oy !== want) begin n_err++; $display("FAIL gap_bit_y: bit %0d got %b want %b", i, oy, want); end
            for (int g = 0; g < 3; g++) begin
                apply(1'b0, 1'($urandom), 1'b0, 1'b0, ey, oy);
                n_vec++;
                if (oy !== 1'b0) begin n_err++; $display("FAIL gap_idle_y: after bit %0d got %b want 0", i, oy); end
            end
        end
        n_vec++;
        if (match_count !== CNT_W'(1)) begin n_err++; $display("FAIL gap_cnt: got %0d want 1", match_count); end
    endtask

    task automatic test_reset_midstream();
        bit   pre[4] = '{1, 1, 1, 0};
        bit   ey;
        logic oy;
        load_cfg(8'b0011_1011, 6, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) apply(1'b1, pre[i], 1'b0, 1'b0, ey, oy);
        rst = 1'b1;
        x_valid = 1'b1;
        x = 1'b1;
        #1;
        n_vec++;
        if (y !== 1'b0) begin n_err++; $display("FAIL midrst_y: got %b want 0", y); end
        x_valid = 1'b0;
        reset_cycle();
        n_vec++;
        if (match_count !== '0 || y !== 1'b0) begin
            n_err++; $display("FAIL midrst_out: got y=%b cnt=%0d want 0/0", y, match_count);
        end
        load_cfg(8'b0011_1011, 6, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, ey, oy);
            n_vec++;
            if (oy !== 1'b0) begin n_err++; $display("FAIL midrst_after_y: bit %0d got %b want 0", i, oy); end
        end
        load_cfg(8'b0011_1011, 6, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) apply(1'b1, pre[i], 1'b0, 1'b0, ey, oy);
        apply(1'b1, 1'b1, 1'b1, 1'b0, ey, oy);
        n_vec++;
        if (oy !== 1'b0) begin n_err++; $display("FAIL load_x_y: got %b want 0", oy); end
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, ey, oy);
            n_vec++;
            if (oy !== 1'b0) begin n_err++; $display("FAIL load_clear_y: bit %0d got %b want 0", i, oy); end
        end
    endtask

    task automatic test_saturate();
        int   want_c[5] = '{1, 2, 3, 3, 3};
        bit   ey;
        logic oy;
        load_cfg(8'b0000_0001, 1, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, ey, oy);
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, ey, oy);
            n_vec++;
            if (oy !== 1'b1) begin n_err++; $display("FAIL sat_y: bit %0d got %b want 1", i, oy); end
            n_vec++;
            if (match_count !== CNT_W'(want_c[i])) begin
                n_err++; $display("FAIL sat_cnt: bit %0d got %0d want %0d", i, match_count, want_c[i]);
            end
        end
        apply(1'b1, 1'b1, 1'b0, 1'b1, ey, oy);
        n_vec++;
        if (match_count !== CNT_W'(1)) begin n_err++; $display("FAIL clr_hit_cnt: got %0d want 1", match_count); end
        apply(1'b0, 1'b0, 1'b0, 1'b1, ey, oy);
        n_vec++;
        if (match_count !== '0) begin n_err++; $display("FAIL clr_cnt: got %0d want 0", match_count); end
        load_cfg(8'b1111_1111, 9, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, ey, oy);
            n_vec++;
            if (oy !== 1'b0) begin n_err++; $display("FAIL len_over_y: bit %0d got %b want 0", i, oy); end
        end
    endtask

    task automatic test_random();
        bit   ey;
        logic oy;
        bit   ld;
        for (int i = 0; i < 600; i++) begin
            ld = ($urandom_range(0, 99) < 4);
            if (ld) begin
                cfg_pattern = MAX_LEN'($urandom);
                cfg_len     = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(0, 15))
                                                          : LEN_W'($urandom_range(1, 4));
                cfg_overlap = 1'($urandom);
                cfg_moore   = 1'($urandom);
            end
            apply($urandom_range(0, 99) < 75, 1'($urandom), ld, $urandom_range(0, 99) < 4, ey, oy);
            n_vec++;
            if (oy !== ey) begin n_err++; $display("FAIL rand_y: cycle %0d got %b want %b", i, oy, ey); end
            n_vec++;
            if (match_count !== CNT_W'(m_cnt)) begin
                n_err++; $display("FAIL rand_cnt: cycle %0d got %0d want %0d", i, match_count, m_cnt);
            end
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        x_valid     = 1'b0;
        x           = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b1;
        cfg_moore   = 1'b0;
        cnt_clear   = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_overlap_mealy();
        test_no_overlap();
        test_moore();
        test_gaps();
        test_reset_midstream();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
